eco32f_regfile: RTL
===================

// Module: eco32f_regfile
// PURPOSE
//  General-purpose register file: the read/store end of the writeback register port.
//  Stores writeback-stage results (wb_rf_r/_we/_addr) and serves the decode stage two registered read ports.
//  Read ports forward same-edge writes, and refresh a held read while decode is stalled.
//  After reset, a sequencer zeroes every entry so the array maps onto block RAM.
// PARAMETERS
//  DW  32  data width of each register
//  AW  5   register address width; NREGS = 2**AW entries; entry 0 is hardwired zero
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst            in   1   synchronous reset, active-low
//  decode_stall   in   1   1 = hold read-port address registers and outputs
//  rf_a_addr      in   AW  read port A address (decode rs)
//  rf_b_addr      in   AW  read port B address (decode rt)
//  rf_a           out  DW  port A data, registered, 1-cycle latency
//  rf_b           out  DW  port B data, registered, 1-cycle latency
//  wb_rf_r        in   DW  writeback data
//  wb_rf_r_we     in   1   writeback write enable
//  wb_rf_r_addr   in   AW  writeback destination register
//  rf_init_busy   out  1   1 while the clear sequencer runs; the pipeline must stall
// BEHAVIOUR
//  - Reset (rst==0 at an edge): state <= INIT, init_cnt <= 0, rf_a/rf_b <= 0, a_q/b_q <= 0, rf_init_busy <= 1.
//  - Reset asserted in any state, including mid-INIT, restarts the sequencer at init_cnt = 0.
//  - FSM INIT: each cycle writes 0 to mem[init_cnt], then init_cnt++.
//    On the edge that writes entry NREGS-1, go to RUN and clear rf_init_busy.
//    rf_init_busy is therefore high for exactly NREGS cycles after rst releases.
//  - In INIT: wb writes are ignored and rf_a/rf_b hold 0.
//  - FSM RUN: no exit except reset.
//  - Write: in RUN, if wb_rf_r_we && wb_rf_r_addr != 0, then mem[wb_rf_r_addr] <= wb_rf_r.
//    Writes to r0 are dropped and r0 always reads 0.
//  - Read, RUN && !decode_stall: a_q <= rf_a_addr; rf_a <= (rf_a_addr==0) ? 0 :
//    (wb_rf_r_we && wb_rf_r_addr==rf_a_addr) ? wb_rf_r : mem[rf_a_addr].
//    This is write-first forwarding, with no extra cycle. Port B is identical using b_q/rf_b_addr.
//  - Read, RUN && decode_stall: a_q and rf_a hold, except when wb_rf_r_we && wb_rf_r_addr==a_q && a_q!=0.
//    In that case rf_a <= wb_rf_r, so a stalled instruction never sees stale data. Port B is identical.
//  - Both ports may address the same register; both forward independently.
//  - The write port and read ports are always concurrent; writes are never blocked by stall.
//  - Width: addresses AW bits with no wrap/overflow; data passes unmodified (no sign or zero extension).
// TESTING
//  1. rst=0 for 2 cycles, then 1 -> rf_init_busy=1 for exactly 32 cycles, then 0.
//     A subsequent read of r5 -> rf_a=0x00000000.
//  2. Write r3=0xDEADBEEF; next cycle rf_a_addr=3 -> rf_a=0xDEADBEEF one cycle later.
//  3. Same edge: write r7=0x12345678 with rf_a_addr=rf_b_addr=7 -> rf_a=rf_b=0x12345678 next cycle.
//  4. Write r0=0xFFFFFFFF, then read r0 on A -> rf_a=0x00000000.
//  5. Set a_q=9, b_q=4 (r4=0x11110000), decode_stall=1, write r9=0xCAFEF00D.
//     -> rf_a=0xCAFEF00D next cycle; rf_b stays 0x11110000; addresses unchanged.
//  6. rst=0 at init_cnt=10 -> after release, init_cnt restarts at 0 and busy lasts 32 cycles.
//     A wb write during INIT to r2=0xAAAA5555 -> r2 reads 0 afterwards.

Source files
------------

// File: rtl/eco32f_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : eco32f_regfile
//  Description : General-purpose register file with two registered,
//                write-forwarding read ports. The contents are cleared by a
//                sequencer after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module eco32f_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          decode_stall,
  input  logic [AW-1:0] rf_a_addr,
  input  logic [AW-1:0] rf_b_addr,
  output logic [DW-1:0] rf_a,
  output logic [DW-1:0] rf_b,
  input  logic [DW-1:0] wb_rf_r,
  input  logic          wb_rf_r_we,
  input  logic [AW-1:0] wb_rf_r_addr,
  output logic          rf_init_busy
);

  localparam int            NREGS   = 2 ** AW;
  localparam logic [AW-1:0] c_LAST  = '1;
  localparam logic [AW-1:0] c_ZERO  = '0;
  localparam logic [0:0]    ST_INIT = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_init_cnt;
  logic          r_busy;
  logic [DW-1:0] r_mem [NREGS];

  logic          w_run;
  logic          w_wr_valid;

  assign w_run        = (r_state == ST_RUN);
  assign w_wr_valid   = w_run && wb_rf_r_we && (wb_rf_r_addr != c_ZERO);
  assign rf_init_busy = r_busy;

  // Clear sequencer: one entry per cycle, then RUN until the next reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= c_ZERO;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == c_LAST) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == ST_INIT) begin
        r_mem[r_init_cnt] <= '0;
      end else if (w_wr_valid) begin
        r_mem[wb_rf_r_addr] <= wb_rf_r;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rd_port
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_q;
    logic [DW-1:0] r_data;
    logic          w_fwd_new;
    logic          w_fwd_held;

    assign w_addr     = (i == 0) ? rf_a_addr : rf_b_addr;
    assign w_fwd_new  = wb_rf_r_we && (wb_rf_r_addr == w_addr);
    assign w_fwd_held = wb_rf_r_we && (wb_rf_r_addr == r_q) && (r_q != c_ZERO);

    // A stalled read still picks up a write to the register it is holding.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_q    <= c_ZERO;
        r_data <= '0;
      end else if (w_run) begin
        if (!decode_stall) begin
          r_q <= w_addr;
          if (w_addr == c_ZERO) begin
            r_data <= '0;
          end else if (w_fwd_new) begin
            r_data <= wb_rf_r;
          end else begin
            r_data <= r_mem[w_addr];
          end
        end else if (w_fwd_held) begin
          r_data <= wb_rf_r;
        end
      end
    end
  end

  assign rf_a = g_rd_port[0].r_data;
  assign rf_b = g_rd_port[1].r_data;

endmodule
`default_nettype wire
